// File: rtl/term_pkg.sv
// Shared character constants and sequencer state encoding for the serial terminal.
package term_pkg;

  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  typedef enum logic [2:0] {
    CLR_HOME,
    CLR,
    FIN_HOME,
    IDLE,
    WRITE,
    NL
  } state_e;

endpackage

// File: rtl/term_ctrl_if.sv
// Byte stream handshake from the serial receiver into the terminal sequencer.
interface term_ctrl_if;

  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;

  modport master (output i_data, output i_valid, input  o_ready);
  modport slave  (input  i_data, input  i_valid, output o_ready);

endinterface

// File: rtl/char_class.sv
// Combinational classifier: printable ASCII, line feed or form feed.
module char_class
  import term_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_is_print,
  output logic       o_is_lf,
  output logic       o_is_ff
);

  assign o_is_print = (i_byte >= CH_PRINT_LO) && (i_byte <= CH_PRINT_HI);
  assign o_is_lf    = (i_byte == CH_LF);
  assign o_is_ff    = (i_byte == CH_FF);

endmodule

// File: rtl/term_ctrl.sv
// Terminal command sequencer: writes characters at the cursor and sweeps for newline/clear.
// Build macro TERM_CTRL_NL_ERASE_EN: newline also blanks from the cursor to end of line.
module term_ctrl
  import term_pkg::*;
#(
  parameter int last_col = 59,
  parameter int last_row = 16,
  parameter int ROW_W    = 5,
  parameter int COL_W    = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  term_ctrl_if.slave             s_byte,
  input  logic [ROW_W-1:0]       i_row,
  input  logic [COL_W-1:0]       i_col,
  output logic                   o_cmd_home,
  output logic                   o_cmd_advance,
  output logic                   o_we,
  output logic [ROW_W+COL_W-1:0] o_addr,
  output logic [7:0]             o_wdata,
  output logic                   o_busy
);

  state_e     r_state;
  logic [7:0] r_byte;

  logic w_is_print;
  logic w_is_lf;
  logic w_is_ff;
  logic w_hs;
  logic w_last_col;
  logic w_last_cell;
  logic w_ready;

  char_class u_char_class (
    .i_byte     (s_byte.i_data),
    .o_is_print (w_is_print),
    .o_is_lf    (w_is_lf),
    .o_is_ff    (w_is_ff)
  );

  assign w_hs        = s_byte.i_valid && (r_state == IDLE);
  assign w_last_col  = (i_col == COL_W'(last_col));
  assign w_last_cell = w_last_col && (i_row == ROW_W'(last_row));

  // NOTE: state is updated with non-blocking assignments so every reader sees the pre-edge value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= CLR_HOME;
      r_byte  <= '0;
    end else begin
      case (r_state)
        CLR_HOME: r_state <= CLR;
        CLR:      if (w_last_cell) r_state <= FIN_HOME;
        FIN_HOME: r_state <= IDLE;
        IDLE: begin
          if (w_hs) begin
            r_byte <= s_byte.i_data;
            if (w_is_print)   r_state <= WRITE;
            else if (w_is_lf) r_state <= NL;
            else if (w_is_ff) r_state <= CLR_HOME;
          end
        end
        WRITE:    r_state <= IDLE;
        NL:       if (w_last_col) r_state <= IDLE;
        default:  r_state <= CLR_HOME;
      endcase
    end
  end

  // NOTE: every output gets a default first so the decode below cannot infer a latch.
  always_comb begin
    o_cmd_home    = 1'b0;
    o_cmd_advance = 1'b0;
    o_we          = 1'b0;
    o_wdata       = 8'h00;
    w_ready       = 1'b0;
    case (r_state)
      CLR_HOME, FIN_HOME: o_cmd_home = 1'b1;
      CLR: begin
        o_we          = 1'b1;
        o_wdata       = CH_SPACE;
        // The final cell is written in place; FIN_HOME repositions the cursor.
        o_cmd_advance = !w_last_cell;
      end
      IDLE: w_ready = 1'b1;
      WRITE: begin
        o_we          = 1'b1;
        o_wdata       = r_byte;
        o_cmd_advance = 1'b1;
      end
      NL: begin
        o_cmd_advance = 1'b1;
`ifdef TERM_CTRL_NL_ERASE_EN
        o_we          = 1'b1;
        o_wdata       = CH_SPACE;
`else
        o_we          = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  assign s_byte.o_ready = w_ready;
  assign o_addr         = {i_row, i_col};
  assign o_busy         = (r_state != IDLE);

endmodule

// File: tb/tb_term_ctrl.sv
// Self-checking bench for term_ctrl: position-counter and RAM models plus a screen/cursor reference.
module tb_term_ctrl;

  localparam int LC = 59;
  localparam int LR = 16;
  localparam int NCELL = (LR + 1) * (LC + 1);
`ifdef TERM_CTRL_NL_ERASE_EN
  localparam bit ERASE = 1'b1;
`else
  localparam bit ERASE = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [4:0]  p_row = '0;
  logic [5:0]  p_col = '0;
  logic        o_cmd_home, o_cmd_advance, o_we, o_busy;
  logic [10:0] o_addr;
  logic [7:0]  o_wdata;

  term_ctrl_if bif ();

  term_ctrl dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .s_byte        (bif),
    .i_row         (p_row),
    .i_col         (p_col),
    .o_cmd_home    (o_cmd_home),
    .o_cmd_advance (o_cmd_advance),
    .o_we          (o_we),
    .o_addr        (o_addr),
    .o_wdata       (o_wdata),
    .o_busy        (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Environment: saturating cursor position counter and text RAM.
  always @(posedge i_clk) begin
    if (o_cmd_home) begin
      p_row <= '0;
      p_col <= '0;
    end else if (o_cmd_advance) begin
      if (p_col == 6'(LC)) begin
        p_col <= '0;
        if (p_row != 5'(LR)) p_row <= p_row + 5'd1;
      end else begin
        p_col <= p_col + 6'd1;
      end
    end
  end

  logic [7:0] ram [0:2047];
  always @(posedge i_clk) if (o_we) ram[o_addr] <= o_wdata;

  // Reference: expected screen contents and cursor.
  logic [7:0] exp_scr [0:NCELL-1];
  int m_row, m_col;
  int n_checks = 0;
  int n_errors = 0;

  // First busy-cycle outputs and per-byte counts captured by send().
  logic [31:0] f_vec;
  int n_cyc, n_adv, n_we, n_both;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {8'd0, o_cmd_home, o_cmd_advance, o_we, bif.o_ready, o_busy,
            (o_we ? o_addr : 11'd0), o_wdata};
  endfunction

  function automatic logic [31:0] mk_vec(input bit home, input bit adv, input bit we,
                                         input bit rdy, input logic [10:0] addr,
                                         input logic [7:0] wd);
    return {8'd0, home, adv, we, rdy, !rdy, (we ? addr : 11'd0), wd};
  endfunction

  function automatic bit is_print(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NCELL; i++) exp_scr[i] = 8'h20;
    m_row = 0;
    m_col = 0;
  endtask

  task automatic model_apply(input logic [7:0] b);
    if (is_print(b)) begin
      exp_scr[m_row * (LC + 1) + m_col] = b;
      if (m_col == LC) begin
        m_col = 0;
        if (m_row < LR) m_row++;
      end else begin
        m_col++;
      end
    end else if (b == 8'h0A) begin
      if (ERASE) for (int c = m_col; c <= LC; c++) exp_scr[m_row * (LC + 1) + c] = 8'h20;
      m_col = 0;
      if (m_row < LR) m_row++;
    end else if (b == 8'h0C) begin
      model_clear();
    end
  endtask

  task automatic check_cursor(input string tag);
    check(tag, {21'd0, p_row, p_col}, {21'd0, 5'(m_row), 6'(m_col)});
  endtask

  task automatic check_screen(input string tag);
    int bad = 0;
    for (int r = 0; r <= LR; r++)
      for (int c = 0; c <= LC; c++)
        if (ram[{5'(r), 6'(c)}] !== exp_scr[r * (LC + 1) + c]) bad++;
    check(tag, bad, 0);
  endtask

  // Called at a negedge where the DUT is in its first (home) cycle of a clear.
  task automatic check_clear(input string tag);
    for (int k = 0; k <= NCELL + 2; k++) begin
      bit e_home, e_we, e_adv, e_rdy;
      int lin;
      e_home = (k == 0) || (k == NCELL + 1);
      e_we   = (k >= 1) && (k <= NCELL);
      e_adv  = e_we && (k != NCELL);
      e_rdy  = (k == NCELL + 2);
      lin    = k - 1;
      check($sformatf("%s_k%0d", tag, k), out_vec(),
            mk_vec(e_home, e_adv, e_we, e_rdy, {5'(lin / (LC + 1)), 6'(lin % (LC + 1))},
                   e_we ? 8'h20 : 8'h00));
      if (k < NCELL + 2) @(negedge i_clk);
    end
    model_clear();
  endtask

  task automatic send(input logic [7:0] b);
    int w = 0;
    while (!bif.o_ready && w < 5000) begin
      @(negedge i_clk);
      w++;
    end
    check("ready_before_send", {31'd0, bif.o_ready}, 32'd1);
    bif.i_data  = b;
    bif.i_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    bif.i_valid = 1'b0;
    f_vec  = out_vec();
    n_cyc  = 0;
    n_adv  = 0;
    n_we   = 0;
    n_both = 0;
    while (!bif.o_ready && n_cyc < 5000) begin
      n_adv  += int'(o_cmd_advance);
      n_we   += int'(o_we);
      n_both += int'(o_cmd_home && o_cmd_advance);
      n_cyc++;
      @(negedge i_clk);
    end
  endtask

  // Send one non-FF byte and check it against the reference rules.
  task automatic do_byte(input string tag, input logic [7:0] b);
    int e_cyc;
    logic [31:0] e_first;
    logic [10:0] cur;
    cur = {5'(m_row), 6'(m_col)};
    if (is_print(b)) begin
      e_cyc   = 1;
      e_first = mk_vec(1'b0, 1'b1, 1'b1, 1'b0, cur, b);
    end else if (b == 8'h0A) begin
      e_cyc   = LC - m_col + 1;
      e_first = mk_vec(1'b0, 1'b1, ERASE, 1'b0, cur, ERASE ? 8'h20 : 8'h00);
    end else begin
      e_cyc   = 0;
      e_first = mk_vec(1'b0, 1'b0, 1'b0, 1'b1, cur, 8'h00);
    end
    send(b);
    check({tag, "_first"}, f_vec, e_first);
    check({tag, "_cycles"}, n_cyc, e_cyc);
    check({tag, "_adv"}, n_adv, e_cyc);
    check({tag, "_we"}, n_we, (is_print(b) || ERASE) ? e_cyc : 0);
    check({tag, "_home_adv"}, n_both, 0);
    model_apply(b);
    check_cursor({tag, "_cursor"});
  endtask

  task automatic move_to(input int r, input int c);
    while (m_row * (LC + 1) + m_col < r * (LC + 1) + c)
      do_byte("mv", 8'($urandom_range(32, 126)));
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    case ($urandom_range(0, 7))
      0:       b = 8'h0A;
      1, 2: begin
        do b = 8'($urandom_range(0, 255));
        while (is_print(b) || b == 8'h0A || b == 8'h0C);
      end
      default: b = 8'($urandom_range(32, 126));
    endcase
    return b;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (observed=timeout expected=finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ign [6];
    ign = '{8'h07, 8'h00, 8'h7F, 8'h1F, 8'h80, 8'hFF};
    i_rst       = 1'b1;
    bif.i_valid = 1'b0;
    bif.i_data  = 8'h00;
    #3;
    check("rst_hold", out_vec(), mk_vec(1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 8'h00));

    // Power-on clear.
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    check_clear("por");
    check_screen("por_screen");
    check_cursor("por_cursor");

    // Single printable at home.
    do_byte("A", 8'h41);

    // Newline near end of row 3.
    move_to(3, 57);
    do_byte("nl_3_57", 8'h0A);
    check_screen("nl_screen");

    // Random mix of printable, LF and ignored bytes.
    for (int i = 0; i < 24; i++) do_byte($sformatf("rnd%0d", i), rand_byte());
    check_screen("rnd_screen");

    // Form feed with the next byte held on the bus throughout the clear.
    bif.i_data  = 8'h0C;
    bif.i_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    bif.i_data = 8'h42;
    check_clear("ff");
    @(posedge i_clk);
    @(negedge i_clk);
    bif.i_valid = 1'b0;
    check("ff_held_write", out_vec(), mk_vec(1'b0, 1'b1, 1'b1, 1'b0, 11'd0, 8'h42));
    model_apply(8'h42);
    @(negedge i_clk);
    check_cursor("ff_held_cursor");
    check_screen("ff_screen");

    // Last cell, then newline on the saturated last row.
    move_to(LR, LC);
    do_byte("last_cell", 8'h5A);
    do_byte("nl_last_row", 8'h0A);
    check_screen("last_screen");

    // Reset in the middle of a clear sweep.
    bif.i_data  = 8'h0C;
    bif.i_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    bif.i_valid = 1'b0;
    for (int n = 0; n < 2000 && !(o_we && p_row == 5'd5 && p_col == 6'd10); n++)
      @(negedge i_clk);
    check("reach_5_10", {20'd0, o_we, p_row, p_col}, {20'd0, 1'b1, 5'd5, 6'd10});
    #2 i_rst = 1'b1;
    #1;
    check("async_rst", out_vec(), mk_vec(1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 8'h00));
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    check_clear("rst_restart");
    check_screen("rst_screen");

    // Ignored control bytes and printable range edges.
    for (int i = 0; i < 6; i++) do_byte($sformatf("ign%0d", i), ign[i]);
    do_byte("lo_edge", 8'h20);
    do_byte("hi_edge", 8'h7E);
    check_screen("final_screen");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
